// File: rtl/uart_byte_tx_if.sv
// Byte handshake and serial-line bundle between the byte splitter and the UART transmitter.
interface uart_byte_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic       overrun;

  modport master (
    output data_in, data_valid,
    input  tx, busy, tx_done, overrun
  );

  modport slave (
    input  data_in, data_valid,
    output tx, busy, tx_done, overrun
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1/8N2 UART byte transmitter with a one-byte holding register for gapless back-to-back frames.
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte strobe
//   S_START | start bit (line low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | STOP_BITS stop bits (line high); last cycle chains or returns to idle
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [2:0]      r_bit, w_bit_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [7:0]      r_hold, w_hold_nx;
  logic            r_hold_full, w_hold_full_nx;
  logic            r_tx, w_tx_nx;
  logic            r_busy, w_busy_nx;
  logic            r_tx_done, w_tx_done_nx;
  logic            r_overrun, w_overrun_nx;
  logic            w_bit_end;

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt + 1'b1;
    w_bit_nx       = r_bit;
    w_shift_nx     = r_shift;
    w_hold_nx      = r_hold;
    w_hold_full_nx = r_hold_full;
    w_tx_done_nx   = 1'b0;
    w_overrun_nx   = r_overrun;
    w_bit_end      = (r_cnt == CNT_LAST);

    // Mid-frame strobes land in the holding register; the drain case below overrides this.
    if (r_state != S_IDLE && bus.data_valid) begin
      if (!r_hold_full) begin
        w_hold_nx      = bus.data_in;
        w_hold_full_nx = 1'b1;
      end else begin
        w_overrun_nx = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_bit_nx = 3'd0;
        if (bus.data_valid) begin
          w_shift_nx = bus.data_in;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_bit == 3'd7) begin
            w_bit_nx   = 3'd0;
            w_state_nx = S_STOP;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_shift_nx = r_shift >> 1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_bit == STOP_LAST) begin
            w_tx_done_nx = 1'b1;
            w_bit_nx     = 3'd0;
            if (r_hold_full) begin
              // Drain the held byte; a strobe in this same cycle refills the register.
              w_shift_nx     = r_hold;
              w_state_nx     = S_START;
              w_overrun_nx   = r_overrun;
              w_hold_full_nx = bus.data_valid;
              w_hold_nx      = bus.data_valid ? bus.data_in : r_hold;
            end else if (bus.data_valid) begin
              w_shift_nx     = bus.data_in;
              w_hold_full_nx = 1'b0;
              w_state_nx     = S_START;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit       <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_hold      <= w_hold_nx;
      r_hold_full <= w_hold_full_nx;
      r_tx        <= w_tx_nx;
      r_busy      <= w_busy_nx;
      r_tx_done   <= w_tx_done_nx;
      r_overrun   <= w_overrun_nx;
    end
  end

  assign bus.tx      = r_tx;
  assign bus.busy    = r_busy;
  assign bus.tx_done = r_tx_done;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: two instances (CLKS_PER_BIT=4 with one and two stop bits).
module tb_uart_byte_tx;
  localparam int NMAX = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_byte_tx_if if1();
  uart_byte_tx_if if2();

  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  int total = 0;
  int bad   = 0;

  logic       cap_tx   [NMAX];
  logic       cap_busy [NMAX];
  logic       cap_done [NMAX];
  logic       cap_ovr  [NMAX];
  logic       sv       [NMAX];
  logic [7:0] sd       [NMAX];
  logic       sr       [NMAX];

  // Expected line level in cycle c for a frame whose start bit begins at cycle s (4 clocks/bit).
  function automatic logic exp_tx(input int c, input int s, input logic [7:0] b);
    int rel;
    logic [7:0] t;
    rel = c - s;
    if (rel < 0)  return 1'b1;
    if (rel < 4)  return 1'b0;
    if (rel < 36) begin
      t = b >> ((rel - 4) / 4);
      return t[0];
    end
    return 1'b1;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < NMAX; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
      sr[i] = 1'b0;
    end
  endtask

  // Iteration c samples the outputs of cycle c, then drives the inputs for cycle c.
  task automatic run(input int which, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_tx[c]   = (which == 1) ? if1.tx      : if2.tx;
      cap_busy[c] = (which == 1) ? if1.busy    : if2.busy;
      cap_done[c] = (which == 1) ? if1.tx_done : if2.tx_done;
      cap_ovr[c]  = (which == 1) ? if1.overrun : if2.overrun;
      rst = sr[c];
      if1.data_valid = (which == 1) ? sv[c] : 1'b0;
      if1.data_in    = sd[c];
      if2.data_valid = (which == 2) ? sv[c] : 1'b0;
      if2.data_in    = sd[c];
    end
    @(negedge clk);
    rst = 1'b0;
    if1.data_valid = 1'b0;
    if2.data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.data_valid = 1'b0; if1.data_in = 8'h00;
    if2.data_valid = 1'b0; if2.data_in = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total += 8;
      if (if1.tx !== 1'b1)      begin bad++; $display("FAIL reset_tx1 k=%0d got=%b exp=1", k, if1.tx); end
      if (if1.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy1 k=%0d got=%b exp=0", k, if1.busy); end
      if (if1.tx_done !== 1'b0) begin bad++; $display("FAIL reset_done1 k=%0d got=%b exp=0", k, if1.tx_done); end
      if (if1.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr1 k=%0d got=%b exp=0", k, if1.overrun); end
      if (if2.tx !== 1'b1)      begin bad++; $display("FAIL reset_tx2 k=%0d got=%b exp=1", k, if2.tx); end
      if (if2.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy2 k=%0d got=%b exp=0", k, if2.busy); end
      if (if2.tx_done !== 1'b0) begin bad++; $display("FAIL reset_done2 k=%0d got=%b exp=0", k, if2.tx_done); end
      if (if2.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr2 k=%0d got=%b exp=0", k, if2.overrun); end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic et, eb, ed;
    clear_sched();
    sv[0] = 1'b1; sd[0] = 8'hA5;
    run(1, 46);
    for (int c = 0; c < 46; c++) begin
      et = exp_tx(c, 1, 8'hA5);
      eb = (c >= 1 && c <= 40);
      ed = (c == 41);
      total += 4;
      if (cap_tx[c] !== et)     begin bad++; $display("FAIL single_tx c=%0d got=%b exp=%b", c, cap_tx[c], et); end
      if (cap_busy[c] !== eb)   begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, cap_busy[c], eb); end
      if (cap_done[c] !== ed)   begin bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, cap_done[c], ed); end
      if (cap_ovr[c] !== 1'b0)  begin bad++; $display("FAIL single_ovr c=%0d got=%b exp=0", c, cap_ovr[c]); end
    end
  endtask

  task automatic test_back_to_back();
    logic et, eb, ed;
    clear_sched();
    sv[0]  = 1'b1; sd[0]  = 8'h3C;
    sv[10] = 1'b1; sd[10] = 8'hC3;
    run(1, 86);
    for (int c = 0; c < 86; c++) begin
      et = (c >= 41) ? exp_tx(c, 41, 8'hC3) : exp_tx(c, 1, 8'h3C);
      eb = (c >= 1 && c <= 80);
      ed = (c == 41 || c == 81);
      total += 3;
      if (cap_tx[c] !== et)   begin bad++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, cap_tx[c], et); end
      if (cap_busy[c] !== eb) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, cap_busy[c], eb); end
      if (cap_done[c] !== ed) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, cap_done[c], ed); end
    end
  endtask

  task automatic test_overrun();
    logic et, eb, ed, eo;
    clear_sched();
    sv[0] = 1'b1; sd[0] = 8'h11;
    sv[5] = 1'b1; sd[5] = 8'h22;
    sv[6] = 1'b1; sd[6] = 8'h33;
    run(1, 96);
    for (int c = 0; c < 96; c++) begin
      et = (c >= 41) ? exp_tx(c, 41, 8'h22) : exp_tx(c, 1, 8'h11);
      eb = (c >= 1 && c <= 80);
      ed = (c == 41 || c == 81);
      eo = (c >= 7);
      total += 4;
      if (cap_tx[c] !== et)   begin bad++; $display("FAIL ovr_tx c=%0d got=%b exp=%b", c, cap_tx[c], et); end
      if (cap_busy[c] !== eb) begin bad++; $display("FAIL ovr_busy c=%0d got=%b exp=%b", c, cap_busy[c], eb); end
      if (cap_done[c] !== ed) begin bad++; $display("FAIL ovr_done c=%0d got=%b exp=%b", c, cap_done[c], ed); end
      if (cap_ovr[c] !== eo)  begin bad++; $display("FAIL ovr_flag c=%0d got=%b exp=%b", c, cap_ovr[c], eo); end
    end
  endtask

  task automatic test_reset_mid();
    logic et, eb;
    do_reset();
    clear_sched();
    sv[0] = 1'b1; sd[0] = 8'h3C;
    sv[5] = 1'b1; sd[5] = 8'h55;
    sr[20] = 1'b1;
    run(1, 100);
    for (int c = 0; c < 100; c++) begin
      et = (c >= 21) ? 1'b1 : exp_tx(c, 1, 8'h3C);
      eb = (c >= 1 && c <= 20);
      total += 4;
      if (cap_tx[c] !== et)     begin bad++; $display("FAIL rstmid_tx c=%0d got=%b exp=%b", c, cap_tx[c], et); end
      if (cap_busy[c] !== eb)   begin bad++; $display("FAIL rstmid_busy c=%0d got=%b exp=%b", c, cap_busy[c], eb); end
      if (cap_done[c] !== 1'b0) begin bad++; $display("FAIL rstmid_done c=%0d got=%b exp=0", c, cap_done[c]); end
      if (cap_ovr[c] !== 1'b0)  begin bad++; $display("FAIL rstmid_ovr c=%0d got=%b exp=0", c, cap_ovr[c]); end
    end
  endtask

  task automatic test_stop2();
    logic et, eb, ed;
    do_reset();
    clear_sched();
    sv[0]  = 1'b1; sd[0]  = 8'hFF;
    sv[44] = 1'b1; sd[44] = 8'h5A;
    run(2, 96);
    for (int c = 0; c < 96; c++) begin
      et = (c >= 45) ? exp_tx(c, 45, 8'h5A) : exp_tx(c, 1, 8'hFF);
      eb = (c >= 1 && c <= 88);
      ed = (c == 45 || c == 89);
      total += 3;
      if (cap_tx[c] !== et)   begin bad++; $display("FAIL stop2_tx c=%0d got=%b exp=%b", c, cap_tx[c], et); end
      if (cap_busy[c] !== eb) begin bad++; $display("FAIL stop2_busy c=%0d got=%b exp=%b", c, cap_busy[c], eb); end
      if (cap_done[c] !== ed) begin bad++; $display("FAIL stop2_done c=%0d got=%b exp=%b", c, cap_done[c], ed); end
    end
  endtask

  // Upstream splitter stand-in: each tx_done pulse releases the next byte of the word.
  task automatic test_handshake();
    logic [63:0] word;
    logic [7:0]  rx [8];
    logic [7:0]  shreg;
    logic        in_frame;
    logic        saw_ovr;
    int          rel, nrx, ndone, idx;
    word = 64'h0807060504030201;
    nrx = 0; ndone = 0; idx = 0; rel = 0;
    in_frame = 1'b0; saw_ovr = 1'b0; shreg = 8'h00;
    for (int j = 0; j < 8; j++) rx[j] = 8'h00;
    do_reset();
    @(negedge clk);
    if1.data_in = word[7:0];
    if1.data_valid = 1'b1;
    idx = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if1.data_valid = 1'b0;
      if (!in_frame && if1.tx == 1'b0) begin
        in_frame = 1'b1;
        rel = 0;
      end else if (in_frame) begin
        rel++;
        if (rel >= 6 && rel <= 34 && ((rel - 6) % 4) == 0) shreg = {if1.tx, shreg[7:1]};
        if (rel == 38) begin
          in_frame = 1'b0;
          if (nrx < 8) rx[nrx] = shreg;
          nrx++;
        end
      end
      if (if1.overrun !== 1'b0) saw_ovr = 1'b1;
      if (if1.tx_done === 1'b1) begin
        ndone++;
        if (idx < 8) begin
          if1.data_in = word[idx*8 +: 8];
          if1.data_valid = 1'b1;
          idx++;
        end
      end
    end
    total += 3;
    if (ndone !== 8)      begin bad++; $display("FAIL hs_done_count got=%0d exp=8", ndone); end
    if (nrx !== 8)        begin bad++; $display("FAIL hs_frame_count got=%0d exp=8", nrx); end
    if (saw_ovr !== 1'b0) begin bad++; $display("FAIL hs_overrun got=%b exp=0", saw_ovr); end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (rx[j] !== 8'(j + 1)) begin bad++; $display("FAIL hs_byte j=%0d got=%h exp=%h", j, rx[j], 8'(j + 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_stop2();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
